// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: arm delay generator, wait for LED, time the stop press.
// Optional best-time tracking when REACTION_BEST_EN is defined.
module reaction_ctrl #(
  parameter int CNT_W  = 10,
  parameter int MAX_MS = 999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             tick_1ms,
  input  logic             led,
  output logic             load_rand,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             early,
  output logic             timeout
`ifdef REACTION_BEST_EN
  ,
  output logic [CNT_W-1:0] best
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_WAIT  = 3'd2,
    S_TIME  = 3'd3,
    S_DONE  = 3'd4,
    S_EARLY = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_MS);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_result;
  logic             r_timeout;
  logic             w_sat;

  assign w_sat = tick_1ms && (r_cnt == LP_MAX - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ARM;
      S_ARM:   w_next = S_WAIT;
      S_WAIT: begin
        if (stop)     w_next = S_EARLY;
        else if (led) w_next = S_TIME;
      end
      S_TIME: begin
        if (stop)       w_next = S_DONE;
        else if (w_sat) w_next = S_DONE;
      end
      S_DONE:  if (start) w_next = S_ARM;
      S_EARLY: if (start) w_next = S_ARM;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef REACTION_BEST_EN
  logic [CNT_W-1:0] r_best;
  assign best = r_best;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
`ifdef REACTION_BEST_EN
      r_best    <= LP_MAX;
`endif
    end else begin
      case (r_state)
        S_ARM: begin
          r_cnt     <= '0;
          r_result  <= '0;
          r_timeout <= 1'b0;
        end
        S_WAIT: begin
          r_cnt <= '0;
          if (stop) r_result <= '0;
        end
        S_TIME: begin
          if (stop) begin
            r_result <= r_cnt;
`ifdef REACTION_BEST_EN
            if (r_cnt < r_best) r_best <= r_cnt;
`endif
          end else if (w_sat) begin
            r_cnt     <= LP_MAX;
            r_result  <= LP_MAX;
            r_timeout <= 1'b1;
          end else if (tick_1ms) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags are pure state decodes; result/timeout are registers.
  assign load_rand    = (r_state == S_ARM);
  assign busy         = (r_state == S_ARM) || (r_state == S_WAIT) ||
                        (r_state == S_TIME);
  assign result_valid = (r_state == S_DONE);
  assign early        = (r_state == S_EARLY);
  assign result       = r_result;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl; best-time checks only with REACTION_BEST_EN.
module tb_reaction_ctrl;

  localparam int CNT_W  = 10;
  localparam int MAX_MS = 999;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             tick_1ms = 1'b0;
  logic             led = 1'b0;
  logic             load_rand;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             early;
  logic             timeout;
`ifdef REACTION_BEST_EN
  logic [CNT_W-1:0] best;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  reaction_ctrl #(.CNT_W(CNT_W), .MAX_MS(MAX_MS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .tick_1ms     (tick_1ms),
    .led          (led),
    .load_rand    (load_rand),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .early        (early),
    .timeout      (timeout)
`ifdef REACTION_BEST_EN
    ,
    .best         (best)
`endif
  );

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic go_timing();
    pulse_start();
    cyc();
    repeat (3) cyc();
    led = 1'b1;
    cyc();
    led = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_1ms = 1'b1;
      cyc();
      tick_1ms = 1'b0;
      cyc();
    end
  endtask

  task automatic timed_round(input int n);
    go_timing();
    ticks(n);
    pulse_stop();
  endtask

  task automatic chk_reset(input string tag);
    chk_eq({tag, ".load_rand"}, load_rand, 0);
    chk_eq({tag, ".busy"}, busy, 0);
    chk_eq({tag, ".result"}, result, 0);
    chk_eq({tag, ".valid"}, result_valid, 0);
    chk_eq({tag, ".early"}, early, 0);
    chk_eq({tag, ".timeout"}, timeout, 0);
`ifdef REACTION_BEST_EN
    chk_eq({tag, ".best"}, best, MAX_MS);
`endif
  endtask

  initial begin
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk_reset("rst");

    // Round 1: 50-cycle wait then 237 ms
    pulse_start();
    chk_eq("r1.load_rand", load_rand, 1);
    chk_eq("r1.busy_arm", busy, 1);
    cyc();
    chk_eq("r1.load_rand_off", load_rand, 0);
    repeat (48) cyc();
    led = 1'b1;
    cyc();
    chk_eq("r1.busy_time", busy, 1);
    ticks(237);
    chk_eq("r1.no_valid", result_valid, 0);
    pulse_stop();
    led = 1'b0;
    chk_eq("r1.valid", result_valid, 1);
    chk_eq("r1.result", result, 237);
    chk_eq("r1.timeout", timeout, 0);
    chk_eq("r1.busy_done", busy, 0);
    pulse_stop();
    chk_eq("r1.stop_ign", result_valid, 1);
    chk_eq("r1.held", result, 237);

    // Early press, led low
    pulse_start();
    chk_eq("e1.load_rand", load_rand, 1);
    cyc();
    cyc();
    pulse_stop();
    chk_eq("e1.early", early, 1);
    chk_eq("e1.result", result, 0);
    chk_eq("e1.valid", result_valid, 0);

    // Early press with led rising in the same cycle
    pulse_start();
    cyc();
    stop = 1'b1;
    led  = 1'b1;
    cyc();
    stop = 1'b0;
    led  = 1'b0;
    chk_eq("e2.early", early, 1);
    chk_eq("e2.busy", busy, 0);

    // Timeout: DONE on the 999th tick
    go_timing();
    ticks(998);
    chk_eq("to.busy_998", busy, 1);
    chk_eq("to.valid_998", result_valid, 0);
    tick_1ms = 1'b1;
    cyc();
    tick_1ms = 1'b0;
    chk_eq("to.valid", result_valid, 1);
    chk_eq("to.result", result, 999);
    chk_eq("to.timeout", timeout, 1);

    // stop + tick in the same cycle after 10 ticks
    go_timing();
    chk_eq("st.timeout_clr", timeout, 0);
    ticks(10);
    stop     = 1'b1;
    tick_1ms = 1'b1;
    cyc();
    stop     = 1'b0;
    tick_1ms = 1'b0;
    chk_eq("st.result", result, 10);
    chk_eq("st.valid", result_valid, 1);

    // Reset in the middle of TIMING
    go_timing();
    ticks(5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_reset("mid");
    timed_round(42);
    chk_eq("rr.result", result, 42);
    chk_eq("rr.valid", result_valid, 1);

`ifdef REACTION_BEST_EN
    chk_eq("b.after42", best, 42);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    timed_round(300);
    chk_eq("b.300", best, 300);
    timed_round(150);
    chk_eq("b.150", best, 150);
    timed_round(200);
    chk_eq("b.200", best, 150);
    pulse_start();
    cyc();
    pulse_stop();
    chk_eq("b.early_flag", early, 1);
    chk_eq("b.early", best, 150);
    go_timing();
    ticks(999);
    chk_eq("b.to_flag", timeout, 1);
    chk_eq("b.timeout", best, 150);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
Sequencer for the reaction-timer datapath: starts the random delay generator, waits for its LED, then counts 1 ms ticks until the player presses stop. Detects early presses (stop before LED) and no-response timeouts, and holds the result for the display. Sits between the debounced push-buttons, the random delay generator and the 7-segment display driver.

Parameters:
CNT_W, 10, width of the reaction-time counter in bits
MAX_MS, 999, timeout limit in ms; must satisfy MAX_MS < 2**CNT_W

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  debounced start button, one-cycle pulse
stop  input  1  debounced stop button, one-cycle pulse
tick_1ms  input  1  one-cycle pulse every 1 ms
led  input  1  LED output from the delay generator; high = go
load_rand  output  1  one-cycle pulse that starts the delay generator
busy  output  1  high in ARM, WAIT_LED and TIMING
result  output  CNT_W  reaction time in ms; held until the next start
result_valid  output  1  high in DONE
early  output  1  high in EARLY
timeout  output  1  high in DONE when the result saturated at MAX_MS

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high, named reset.
- Reset: state = IDLE; load_rand = 0; busy = 0; result = 0; result_valid = 0; early = 0; timeout = 0. A reset asserted in any state returns to IDLE on the next edge.
- All outputs are registered or decoded from the state register only. No combinational path exists from any input to any output.
- IDLE: on start, go to ARM.
- ARM:
  - Lasts exactly 1 cycle; load_rand = 1 during this cycle only.
  - Clear result, timeout and early.
  - Go to WAIT_LED.
- WAIT_LED:
  - stop = 1 goes to EARLY. This has priority, including when led = 1 in the same cycle.
  - Otherwise, led = 1 goes to TIMING with the counter at 0.
  - start is ignored.
- TIMING:
  - stop = 1: result = counter, go to DONE. stop has priority over a same-cycle tick_1ms; that tick is not counted.
  - Otherwise, tick_1ms increments the counter.
  - When the counter reaches MAX_MS: result = MAX_MS, timeout = 1, go to DONE.
  - start is ignored.
- DONE: result_valid = 1; result is held. start goes to ARM, so a new round begins without passing through IDLE. stop is ignored.
- EARLY: early = 1; result = 0. start goes to ARM.
- Latency:
  - start → load_rand is 1 cycle.
  - led rising in WAIT_LED → TIMING entered on the next edge.
  - stop in TIMING → result_valid high on the next edge.
- Counter: unsigned CNT_W bits; never wraps, saturates at MAX_MS.
- States are binary encoded in 3 bits. Unused encodings go to IDLE on the next edge.

Optional Feature:
Macro: REACTION_BEST_EN.
- Defined: adds output best [CNT_W-1:0], which reset sets to MAX_MS. On each entry to DONE with timeout = 0 and result < best, best = result on the same edge result is written. EARLY and timeout rounds never update best.
- Undefined: no best port and no best register.

Test Plan:
- Reset then start: load_rand high for exactly 1 cycle, one cycle after start. Drive led high after 50 cycles, then give 237 tick_1ms pulses and a stop → result = 237, result_valid = 1, timeout = 0.
- In WAIT_LED, pulse stop with led = 0 → early = 1, result = 0. Repeat with stop and led rising in the same cycle → early = 1.
- In TIMING, give no stop and 999 ticks → result = 999, timeout = 1, DONE reached on the 999th tick.
- In TIMING, stop and tick_1ms in the same cycle after 10 counted ticks → result = 10.
- Assert reset mid-TIMING → every output at its reset value on the next cycle. Then start → a normal round completes.
- With REACTION_BEST_EN: rounds of 300, 150 and 200, followed by an early round and a timeout round → best = 150 throughout after the second round.
